// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiplier and divider blocks:
// FSM state type, counter-width helper and operand-width clamp.
package mul_div_pkg;

  typedef enum logic {IDLE, BUSY} state_e;

  // Step index and add/sub counters must hold values up to WIDTH+1.
  function automatic int unsigned calc_cw(input int unsigned width);
    return $clog2(width + 2);
  endfunction

  // Zero maps to one bit; anything wider than the datapath maps to the datapath width.
  function automatic logic [4:0] clamp_width(input logic [4:0] w, input int unsigned width);
    if (w == 5'd0) begin
      return 5'd1;
    end
    if (32'(w) > width) begin
      return 5'(width);
    end
    return w;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: add or subtract the shifted multiplicand according
// to the current multiplier bit pair.
module booth_step
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = calc_cw(WIDTH),
  localparam int unsigned AW   = 2 * WIDTH + 2
) (
  input  logic [AW-1:0]    acc,
  input  logic [WIDTH-1:0] a,
  input  logic [CW-1:0]    i,
  input  logic [1:0]       pair,
  output logic [AW-1:0]    acc_next,
  output logic             add_en,
  output logic             sub_en
);

  logic [AW-1:0] shifted;

  always_comb begin
    shifted  = AW'(a) << i;
    acc_next = acc;
    add_en   = 1'b0;
    sub_en   = 1'b0;
    unique case (pair)
      2'b01: begin
        acc_next = acc + shifted;
        add_en   = 1'b1;
      end
      2'b10: begin
        acc_next = acc - shifted;
        sub_en   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier for unsigned operands, one step per clock,
// with a ready/done handshake and add/subtract operation counters.
module booth_multiplier
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CW   = calc_cw(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [4:0]           m,
  input  logic [4:0]           n,
  input  logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [CW-1:0]        num_add,
  output logic [CW-1:0]        num_sub
);

  localparam int unsigned AW = 2 * WIDTH + 2;
  localparam logic [WIDTH:0] One = (WIDTH + 1)'(1);

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CW-1:0]        n_eff_q, n_eff_d;
  logic [CW-1:0]        i_q, i_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        add_cnt_q, add_cnt_d;
  logic [CW-1:0]        sub_cnt_q, sub_cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CW-1:0]        num_add_q, num_add_d;
  logic [CW-1:0]        num_sub_q, num_sub_d;

  logic [4:0]           m_eff, n_eff;
  logic [WIDTH-1:0]     mask_a, mask_b;
  logic [WIDTH:0]       b_ext;
  logic [1:0]           pair;
  logic [AW-1:0]        acc_next;
  logic                 add_en, sub_en;

  booth_step #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_step (
    .acc     (acc_q),
    .a       (a_q),
    .i       (i_q),
    .pair    (pair),
    .acc_next(acc_next),
    .add_en  (add_en),
    .sub_en  (sub_en)
  );

  always_comb begin
    m_eff  = clamp_width(m, WIDTH);
    n_eff  = clamp_width(n, WIDTH);
    mask_a = (m == 5'd0) ? '0 : WIDTH'((One << m_eff) - One);
    mask_b = WIDTH'((One << n_eff) - One);

    // Extra zero bit above B supplies B[n_eff]=0 when n_eff equals WIDTH.
    b_ext = {1'b0, b_q};
    pair  = {b_ext[i_q], (i_q == '0) ? 1'b0 : b_ext[i_q - CW'(1)]};

    state_d   = state_q;
    done_d    = done_q;
    a_d       = a_q;
    b_d       = b_q;
    n_eff_d   = n_eff_q;
    i_d       = i_q;
    acc_d     = acc_q;
    add_cnt_d = add_cnt_q;
    sub_cnt_d = sub_cnt_q;
    product_d = product_q;
    num_add_d = num_add_q;
    num_sub_d = num_sub_q;

    unique case (state_q)
      IDLE: begin
        if (ready) begin
          state_d   = BUSY;
          done_d    = 1'b0;
          a_d       = multiplicand & mask_a;
          b_d       = multiplier & mask_b;
          n_eff_d   = CW'(n_eff);
          i_d       = '0;
          acc_d     = '0;
          add_cnt_d = '0;
          sub_cnt_d = '0;
        end
      end
      BUSY: begin
        acc_d     = acc_next;
        add_cnt_d = add_cnt_q + CW'(add_en);
        sub_cnt_d = sub_cnt_q + CW'(sub_en);
        i_d       = i_q + CW'(1);
        if (i_q == n_eff_q) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          product_d = acc_next[2*WIDTH-1:0];
          num_add_d = add_cnt_d;
          num_sub_d = sub_cnt_d;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      done_q    <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      n_eff_q   <= '0;
      i_q       <= '0;
      acc_q     <= '0;
      add_cnt_q <= '0;
      sub_cnt_q <= '0;
      product_q <= '0;
      num_add_q <= '0;
      num_sub_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      a_q       <= a_d;
      b_q       <= b_d;
      n_eff_q   <= n_eff_d;
      i_q       <= i_d;
      acc_q     <= acc_d;
      add_cnt_q <= add_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      product_q <= product_d;
      num_add_q <= num_add_d;
      num_sub_q <= num_sub_d;
    end
  end

  assign done    = done_q;
  assign product = product_q;
  assign num_add = num_add_q;
  assign num_sub = num_sub_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier with hand-computed products,
// counter values and busy latencies.
module tb_booth_multiplier;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CW    = $clog2(WIDTH + 2);

  logic                 clk;
  logic                 reset;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [4:0]           m;
  logic [4:0]           n;
  logic                 ready;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [CW-1:0]        num_add;
  logic [CW-1:0]        num_sub;

  int n_cmp;
  int n_err;

  booth_multiplier #(
    .WIDTH(WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .m           (m),
    .n           (n),
    .ready       (ready),
    .done        (done),
    .product     (product),
    .num_add     (num_add),
    .num_sub     (num_sub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] mm, input logic [4:0] nn);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    m            = mm;
    n            = nn;
    ready        = 1'b1;
    @(negedge clk);
    ready        = 1'b0;
    multiplicand = '1;
    multiplier   = '1;
  endtask

  // Counts negedges with done low; called at the first negedge after the accept edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done == 1'b0 && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] mm, input logic [4:0] nn,
                        input int ep, input int ea, input int es, input int el);
    int lat;
    drive_req(a, b, mm, nn);
    wait_done(lat);
    check_eq({tag, " product"}, 64'(product), 64'(ep));
    check_eq({tag, " num_add"}, 64'(num_add), 64'(ea));
    check_eq({tag, " num_sub"}, 64'(num_sub), 64'(es));
    check_eq({tag, " latency"}, 64'(lat), 64'(el));
  endtask

  initial begin
    int lat;
    int hi_cnt;
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    ready        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    m            = '0;
    n            = '0;
    repeat (2) @(negedge clk);
    check_eq("reset done", 64'(done), 64'd1);
    check_eq("reset product", 64'(product), 64'd0);
    check_eq("reset num_add", 64'(num_add), 64'd0);
    check_eq("reset num_sub", 64'(num_sub), 64'd0);
    reset = 1'b0;

    run_op("7x2", 16'd7, 16'd2, 5'd3, 5'd2, 14, 1, 1, 3);
    run_op("6x3", 16'd6, 16'd3, 5'd3, 5'd2, 18, 1, 1, 3);

    // ready pulsed while busy must be ignored and outputs held.
    drive_req(16'd45, 16'd7, 5'd6, 5'd3);
    check_eq("busy hold product", 64'(product), 64'd18);
    multiplicand = 16'd100;
    multiplier   = 16'd17;
    m            = 5'd7;
    n            = 5'd5;
    ready        = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check_eq("busy hold done", 64'(done), 64'd0);
    check_eq("busy hold product2", 64'(product), 64'd18);
    check_eq("busy hold num_add", 64'(num_add), 64'd1);
    wait_done(lat);
    check_eq("45x7 product", 64'(product), 64'd315);
    check_eq("45x7 num_add", 64'(num_add), 64'd1);
    check_eq("45x7 num_sub", 64'(num_sub), 64'd1);
    check_eq("45x7 latency", 64'(lat + 1), 64'd4);
    repeat (2) @(negedge clk);
    check_eq("no queued op done", 64'(done), 64'd1);
    check_eq("no queued op product", 64'(product), 64'd315);

    run_op("100x17", 16'd100, 16'd17, 5'd7, 5'd5, 1700, 2, 2, 6);
    run_op("513x65", 16'd513, 16'd65, 5'd10, 5'd7, 33345, 2, 2, 8);
    run_op("16x3 masked", 16'd16, 16'd3, 5'd3, 5'd2, 0, 1, 1, 3);
    run_op("5x1 n0", 16'd5, 16'd1, 5'd3, 5'd0, 5, 1, 1, 2);

    // ready held high: done high for one cycle between back-to-back ops.
    @(negedge clk);
    multiplicand = 16'd7;
    multiplier   = 16'd2;
    m            = 5'd3;
    n            = 5'd2;
    ready        = 1'b1;
    @(negedge clk);
    wait_done(lat);
    check_eq("b2b first product", 64'(product), 64'd14);
    hi_cnt = 0;
    while (done == 1'b1 && hi_cnt < 10) begin
      hi_cnt++;
      @(negedge clk);
    end
    check_eq("b2b done high cycles", 64'(hi_cnt), 64'd1);
    ready = 1'b0;
    wait_done(lat);
    check_eq("b2b second product", 64'(product), 64'd14);
    check_eq("b2b second latency", 64'(lat), 64'd3);

    // Reset mid-operation aborts and clears outputs.
    drive_req(16'd100, 16'd17, 5'd7, 5'd5);
    @(negedge clk);
    check_eq("pre-abort done", 64'(done), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort done", 64'(done), 64'd1);
    check_eq("abort product", 64'(product), 64'd0);
    check_eq("abort num_add", 64'(num_add), 64'd0);
    check_eq("abort num_sub", 64'(num_sub), 64'd0);
    run_op("post-abort 7x2", 16'd7, 16'd2, 5'd3, 5'd2, 14, 1, 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
